// File: rtl/multimem_pkg.sv
// Shared types and constants for the double-buffered, width-converting frame memory.
package multimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_PEND = 2'd2
  } state_e;

  localparam int unsigned DROP_W = 8;

endpackage

// File: rtl/multimem_pingpong_if.sv
// Write, read, swap and clear signal bundle between the frame memory and its users.
interface multimem_pingpong_if #(
  parameter int unsigned WR_WIDTH = 8,
  parameter int unsigned RATIO    = 2,
  parameter int unsigned RD_DEPTH = 2048
);
  import multimem_pkg::*;

  localparam int unsigned RA_W     = $clog2(RD_DEPTH);
  localparam int unsigned LW       = (RATIO > 1) ? $clog2(RATIO) : 0;
  localparam int unsigned WA_W     = RA_W + LW;
  localparam int unsigned RD_WIDTH = WR_WIDTH * RATIO;

  logic                wr_en;
  logic [WA_W-1:0]     wr_addr;
  logic [WR_WIDTH-1:0] wr_data;
  logic                wr_ready;
  logic                rd_en;
  logic [RA_W-1:0]     rd_addr;
  logic [RD_WIDTH-1:0] rd_data;
  logic                rd_valid;
  logic                frame_sync;
  logic                swap_req;
  logic                swap_ack;
  logic                clear_req;
  logic [WR_WIDTH-1:0] clear_value;
  logic                clear_done;
  logic                front_sel;
  logic [DROP_W-1:0]   drop_count;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_sync, swap_req, clear_req, clear_value,
    output wr_ready, rd_data, rd_valid, swap_ack, clear_done, front_sel, drop_count
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_sync, swap_req, clear_req, clear_value,
    input  wr_ready, rd_data, rd_valid, swap_ack, clear_done, front_sel, drop_count
  );

endinterface

// File: rtl/multimem_lane_ram.sv
// One lane of the frame memory: simple dual-port RAM holding both banks, bank bit in the address MSB.
module multimem_lane_ram #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register holds its value between reads and is the only reset state in the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multimem_pingpong.sv
// Double-buffered frame memory: narrow writes fill the back bank, wide reads scan the front bank,
// banks swap on a read-side frame boundary; supports back-bank clear and write drop counting.
module multimem_pingpong
  import multimem_pkg::*;
#(
  parameter int unsigned WR_WIDTH = 8,
  parameter int unsigned RATIO    = 2,
  parameter int unsigned RD_DEPTH = 2048
) (
  input logic                 clk,
  input logic                 rst_n,
  multimem_pingpong_if.slave  bus
);

  localparam int unsigned RA_W = $clog2(RD_DEPTH);
  localparam int unsigned LW   = (RATIO > 1) ? $clog2(RATIO) : 0;
  localparam int unsigned LW_S = (LW > 0) ? LW : 1;
  localparam int unsigned BA_W = RA_W + 1;

  state_e              state_q, state_d;
  logic                front_q, front_d;
  logic                pend_q, pend_d;
  logic [RA_W-1:0]     cnt_q, cnt_d;
  logic [WR_WIDTH-1:0] clr_val_q, clr_val_d;
  logic                swap_ack_q, swap_ack_d;
  logic                clear_done_q, clear_done_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                rd_valid_q;

  logic                wr_ready_c;
  logic                wr_fire;
  logic                clearing;
  logic [RA_W-1:0]     wr_row;
  logic [LW_S-1:0]     wr_lane;
  logic [BA_W-1:0]     ram_waddr;
  logic [BA_W-1:0]     ram_raddr;
  logic [WR_WIDTH-1:0] ram_wdata;

  assign wr_ready_c = (state_q == ST_IDLE);
  assign clearing   = (state_q == ST_CLEAR);
  assign wr_fire    = bus.wr_en & wr_ready_c;
  assign wr_row     = RA_W'(bus.wr_addr >> LW);
  assign wr_lane    = LW_S'(bus.wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      front_q      <= 1'b0;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
      clr_val_q    <= '0;
      swap_ack_q   <= 1'b0;
      clear_done_q <= 1'b0;
      drop_q       <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      clr_val_q    <= clr_val_d;
      swap_ack_q   <= swap_ack_d;
      clear_done_q <= clear_done_d;
      drop_q       <= drop_d;
      rd_valid_q   <= bus.rd_en;
    end
  end

  // Next-state logic; a SwapReq arriving in the swap cycle itself re-arms the pending flag.
  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    pend_d       = pend_q | bus.swap_req;
    cnt_d        = cnt_q;
    clr_val_d    = clr_val_q;
    swap_ack_d   = 1'b0;
    clear_done_d = 1'b0;
    drop_d       = drop_q;

    if (bus.wr_en && !wr_ready_c && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          clr_val_d = bus.clear_value;
        end else if (pend_q) begin
          state_d = ST_SWAP_PEND;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + RA_W'(1);
        if (cnt_q == RA_W'(RD_DEPTH - 1)) begin
          clear_done_d = 1'b1;
          state_d      = pend_d ? ST_SWAP_PEND : ST_IDLE;
        end
      end
      ST_SWAP_PEND: begin
        if (bus.frame_sync) begin
          front_d    = ~front_q;
          pend_d     = bus.swap_req;
          swap_ack_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_waddr = {~front_q, (clearing ? cnt_q : wr_row)};
  assign ram_raddr = {front_q, bus.rd_addr};
  assign ram_wdata = clearing ? clr_val_q : bus.wr_data;

  // One RAM per lane; a clear writes every lane of the row at once.
  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    logic lane_we;
    assign lane_we = clearing | (wr_fire & ((RATIO == 1) | (wr_lane == LW_S'(l))));

    multimem_lane_ram #(
      .W  (WR_WIDTH),
      .AW (BA_W)
    ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (lane_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (bus.rd_en),
      .raddr_i (ram_raddr),
      .rdata_o (bus.rd_data[l*WR_WIDTH +: WR_WIDTH])
    );
  end

  assign bus.wr_ready   = wr_ready_c;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.clear_done = clear_done_q;
  assign bus.front_sel  = front_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_multimem_pingpong.sv
// Directed self-checking bench for multimem_pingpong with RATIO=2, RD_DEPTH=16.
module tb_multimem_pingpong;

  localparam int unsigned WR_WIDTH = 8;
  localparam int unsigned RATIO    = 2;
  localparam int unsigned RD_DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multimem_pingpong_if #(.WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .RD_DEPTH(RD_DEPTH)) bus ();

  multimem_pingpong #(.WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .RD_DEPTH(RD_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.frame_sync = 0;
    bus.swap_req = 0; bus.clear_req = 0; bus.clear_value = '0;
    #22;
    n_checks++; if (bus.rd_data !== 16'h0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd: data=%h valid=%b exp 0000/0", bus.rd_data, bus.rd_valid); end
    n_checks++; if (bus.swap_ack !== 1'b0 || bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: ack=%b done=%b exp 0/0", bus.swap_ack, bus.clear_done); end
    n_checks++; if (bus.front_sel !== 1'b0 || bus.drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_state: front=%b drop=%0d exp 0/0", bus.front_sel, bus.drop_count); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b exp 1", bus.wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_swap();
    logic [7:0] wd [4];
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1; bus.wr_addr = 5'(i); bus.wr_data = wd[i];
      tick();
    end
    bus.wr_en = 0;
    bus.swap_req = 1; tick(); bus.swap_req = 0;
    tick();
    n_checks++; if (bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b0) begin n_fail++; $display("FAIL pre_swap: front=%b ack=%b exp 0/0", bus.front_sel, bus.swap_ack); end
    bus.frame_sync = 1; tick(); bus.frame_sync = 0;
    n_checks++; if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b1) begin n_fail++; $display("FAIL swap: front=%b ack=%b exp 1/1", bus.front_sel, bus.swap_ack); end
    tick();
    n_checks++; if (bus.swap_ack !== 1'b0) begin n_fail++; $display("FAIL swap_ack_pulse: got %b exp 0", bus.swap_ack); end
    bus.rd_en = 1; bus.rd_addr = 4'd0; tick();
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h2211) begin n_fail++; $display("FAIL read0: data=%h valid=%b exp 2211/1", bus.rd_data, bus.rd_valid); end
    bus.rd_addr = 4'd1; tick();
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h4433) begin n_fail++; $display("FAIL read1: data=%h valid=%b exp 4433/1", bus.rd_data, bus.rd_valid); end
    bus.rd_en = 0; tick();
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h4433) begin n_fail++; $display("FAIL read_hold: data=%h valid=%b exp 4433/0", bus.rd_data, bus.rd_valid); end
  endtask

  task automatic test_drop();
    bus.swap_req = 1; tick(); bus.swap_req = 0;
    tick();
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL swap_pend_ready: got %b exp 0", bus.wr_ready); end
    bus.wr_en = 1; bus.wr_addr = 5'd0; bus.wr_data = 8'hEE;
    for (int i = 0; i < 3; i++) tick();
    bus.wr_en = 0;
    n_checks++; if (bus.drop_count !== 8'd3) begin n_fail++; $display("FAIL drop3: got %0d exp 3", bus.drop_count); end
    bus.wr_en = 1;
    for (int i = 0; i < 297; i++) tick();
    bus.wr_en = 0;
    n_checks++; if (bus.drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d exp 255", bus.drop_count); end
    bus.frame_sync = 1; tick(); bus.frame_sync = 0;
    n_checks++; if (bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b1) begin n_fail++; $display("FAIL drop_swap: front=%b ack=%b exp 0/1", bus.front_sel, bus.swap_ack); end
    tick();
  endtask

  task automatic test_clear();
    int cnt = 0;
    int g   = 0;
    bus.clear_value = 8'hA5; bus.clear_req = 1; tick(); bus.clear_req = 0;
    bus.clear_value = 8'h00;
    while (!bus.wr_ready && g < 40) begin
      cnt++; g++;
      tick();
    end
    n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL clear_len: got %0d busy cycles exp 16", cnt); end
    n_checks++; if (bus.clear_done !== 1'b1) begin n_fail++; $display("FAIL clear_done: got %b exp 1", bus.clear_done); end
    tick();
    n_checks++; if (bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL clear_done_pulse: got %b exp 0", bus.clear_done); end
    bus.swap_req = 1; tick(); bus.swap_req = 0; tick();
    bus.frame_sync = 1; tick(); bus.frame_sync = 0;
    n_checks++; if (bus.front_sel !== 1'b1) begin n_fail++; $display("FAIL clear_swap: front=%b exp 1", bus.front_sel); end
    bus.rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 4'(i); tick();
      n_checks++; if (bus.rd_data !== 16'hA5A5) begin n_fail++; $display("FAIL clear_row%0d: got %h exp a5a5", i, bus.rd_data); end
    end
    bus.rd_en = 0;
  endtask

  task automatic test_swap_during_clear();
    int g = 0;
    bus.clear_value = 8'h3C; bus.clear_req = 1; tick(); bus.clear_req = 0;
    bus.swap_req = 1; tick(); bus.swap_req = 0;
    bus.frame_sync = 1; tick(); bus.frame_sync = 0;
    n_checks++; if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b0) begin n_fail++; $display("FAIL clear_no_swap: front=%b ack=%b exp 1/0", bus.front_sel, bus.swap_ack); end
    while (bus.clear_done !== 1'b1 && g < 40) begin g++; tick(); end
    n_checks++; if (bus.clear_done !== 1'b1) begin n_fail++; $display("FAIL clear2_timeout: done=%b exp 1", bus.clear_done); end
    n_checks++; if (bus.wr_ready !== 1'b0 || bus.front_sel !== 1'b1) begin n_fail++; $display("FAIL post_clear_pend: ready=%b front=%b exp 0/1", bus.wr_ready, bus.front_sel); end
    bus.frame_sync = 1; tick(); bus.frame_sync = 0;
    n_checks++; if (bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b1) begin n_fail++; $display("FAIL post_clear_swap: front=%b ack=%b exp 0/1", bus.front_sel, bus.swap_ack); end
    bus.rd_en = 1; bus.rd_addr = 4'd5; tick(); bus.rd_en = 0;
    n_checks++; if (bus.rd_data !== 16'h3C3C) begin n_fail++; $display("FAIL clear2_row5: got %h exp 3c3c", bus.rd_data); end
  endtask

  task automatic test_back_to_back();
    bus.wr_en = 1; bus.wr_addr = 5'd0; bus.wr_data = 8'h77; tick(); bus.wr_en = 0;
    bus.swap_req = 1; tick(); bus.swap_req = 0; tick();
    bus.swap_req = 1; tick(); bus.swap_req = 0;
    bus.frame_sync = 1; bus.rd_en = 1; bus.rd_addr = 4'd0; tick();
    bus.frame_sync = 0;
    n_checks++; if (bus.rd_data !== 16'h3C3C || bus.front_sel !== 1'b1) begin n_fail++; $display("FAIL swap_cycle_read: data=%h front=%b exp 3c3c/1", bus.rd_data, bus.front_sel); end
    tick(); bus.rd_en = 0;
    n_checks++; if (bus.rd_data !== 16'hA577) begin n_fail++; $display("FAIL new_front_read: got %h exp a577", bus.rd_data); end
    tick(); tick();
    bus.frame_sync = 1; tick(); bus.frame_sync = 0;
    n_checks++; if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b0) begin n_fail++; $display("FAIL merged_swap: front=%b ack=%b exp 1/0", bus.front_sel, bus.swap_ack); end
  endtask

  task automatic test_reset_mid_clear();
    bus.clear_value = 8'h5A; bus.clear_req = 1; tick(); bus.clear_req = 0;
    tick(); tick(); tick();
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_clear_busy: ready=%b exp 0", bus.wr_ready); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.front_sel !== 1'b0 || bus.drop_count !== 8'd0 || bus.rd_data !== 16'h0) begin n_fail++; $display("FAIL async_reset: front=%b drop=%0d data=%h exp 0/0/0000", bus.front_sel, bus.drop_count, bus.rd_data); end
    n_checks++; if (bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0 || bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl: ready=%b valid=%b done=%b exp 1/0/0", bus.wr_ready, bus.rd_valid, bus.clear_done); end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    n_checks++; if (bus.wr_ready !== 1'b1 || bus.front_sel !== 1'b0 || bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL post_reset: ready=%b front=%b done=%b exp 1/0/0", bus.wr_ready, bus.front_sel, bus.clear_done); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_swap();
    test_drop();
    test_clear();
    test_swap_during_clear();
    test_back_to_back();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multimem_pingpong.md
Name: multimem_pingpong

Overview:
- Parametrised, double-buffered, width-converting frame memory for the LED display path.
- Narrow write port fills the back bank; the wide read port is lane-concatenated and scans the front bank.
- Banks swap only at a read-side frame boundary, through a request/acknowledge handshake.
- Adds a back-bank hardware clear, write back-pressure and a drop counter; single clock domain.

Parameters:
- WR_WIDTH, 8, write-port data width in bits.
- RATIO, 2, lanes per read word; power of two, ≥1; RD_WIDTH = WR_WIDTH*RATIO.
- RD_DEPTH, 2048, read words per bank; power of two.
- Derived: RA_W = clog2(RD_DEPTH), LW = clog2(RATIO) (0 when RATIO=1), WA_W = RA_W+LW.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- WrEn  in  1  write strobe.
- WrAddress  in  WA_W  narrow word address; low LW bits select the lane.
- WrData  in  WR_WIDTH  write data.
- WrReady  out  1  writes accepted this cycle.
- RdEn  in  1  read strobe.
- RdAddress  in  RA_W  wide word address into the front bank.
- RdData  out  RD_WIDTH  read data; lane 0 in the LSBs.
- RdValid  out  1  RdData valid.
- FrameSync  in  1  one-cycle pulse at the read-side frame boundary.
- SwapReq  in  1  pulse: request a bank swap.
- SwapAck  out  1  pulse: swap performed.
- ClearReq  in  1  pulse: fill the back bank with ClearValue.
- ClearValue  in  WR_WIDTH  fill value, replicated to all lanes.
- ClearDone  out  1  pulse: clear finished.
- FrontSel  out  1  index of the bank being read.
- DropCount  out  8  saturating count of rejected writes.

Behaviour:
- Reset values, held while Reset is low:
  - state IDLE; FrontSel 0; swap_pending 0.
  - RdData 0; RdValid 0; SwapAck 0; ClearDone 0; DropCount 0.
  - Memory contents are not initialised. Reset during CLEAR aborts the clear and leaves contents partial.
- States:
  - IDLE, CLEAR, SWAP_PEND.
  - WrReady = (state==IDLE), combinational.
- Writes:
  - WrEn & WrReady writes WrData to back bank (~FrontSel), row WrAddress[WA_W-1:LW], lane WrAddress[LW-1:0]. Other lanes are untouched.
  - WrEn & ~WrReady drops the write and increments DropCount, saturating at 255.
- Reads:
  - RdEn samples the front bank at the edge; RdData and RdValid are registered with 1-cycle latency.
  - RdValid = RdEn delayed one cycle. RdData holds its value when RdEn=0.
  - A read issued in the swap cycle returns the pre-swap front bank.
- swap_pending:
  - Set by SwapReq in any state; cleared when the swap executes. Repeated SwapReq while pending merges into one swap.
- IDLE transitions:
  - ClearReq → CLEAR. Clear has priority over a pending swap.
  - else swap_pending → SWAP_PEND.
- CLEAR:
  - Row counter runs 0..RD_DEPTH-1, one row per cycle. Each cycle writes {RATIO{ClearValue}} to back bank row = counter; ClearValue is sampled at entry.
  - After the last row: ClearDone pulses the next cycle and state → IDLE, or → SWAP_PEND if pending.
  - Clear takes exactly RD_DEPTH cycles of WrReady=0.
  - ClearReq while in CLEAR is ignored.
- SWAP_PEND:
  - Waits for FrameSync. On FrameSync: FrontSel toggles, swap_pending clears, state → IDLE, SwapAck pulses the following cycle.
  - FrameSync in the same cycle as entry into SWAP_PEND does not count; the first qualifying FrameSync is the one after entry.
  - FrameSync outside SWAP_PEND has no effect.
- Reads never touch the back bank, so there is no read/write collision.

Decomposition:
- Package multimem_pkg: state enum (IDLE, CLEAR, SWAP_PEND) and the DropCount width constant (8).
- Sub-module multimem_lane_ram:
  - Simple dual-port, synchronous-read RAM, WR_WIDTH × 2*RD_DEPTH; bank bit is the MSB of the address.
  - Instantiated RATIO times, one per lane.
- Lane write enable = write/clear enable & (lane match | clearing).

Test Plan:
- RATIO=2, write 0x11@0, 0x22@1, 0x33@2, 0x44@3; SwapReq; FrameSync → SwapAck 1 cycle later, FrontSel=1. Read 0 → 0x2211, read 1 → 0x4433, each with RdValid 1 cycle after RdEn.
- SwapReq, then writes during SWAP_PEND → WrReady=0, 3 attempted writes give DropCount=3, memory unchanged. Drive 300 rejected writes → DropCount=255.
- ClearReq with ClearValue 0xA5, RD_DEPTH=16 → WrReady low 16 cycles, ClearDone pulse; after swap, every row reads 0xA5A5.
- SwapReq during CLEAR → no swap until ClearDone; first FrameSync after that toggles FrontSel.
- Read with RdEn in the FrameSync swap cycle → old front data returned. Two SwapReqs before FrameSync → a single toggle.
- Reset low mid-clear → all outputs return to reset values immediately (asynchronous); after release, WrReady=1, FrontSel=0.
